// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan
// Brief   : Multiplexed N-digit seven-segment driver with frame-synchronous
//           display update and per-digit flashing. Optional decimal-point
//           path enabled by defining SEVEN_SEG_DP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int FLASH_DIV  = 250000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   flash_mask,
`ifdef SEVEN_SEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [0:0]              dp_out,
`endif
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int FLASH_W = $clog2(FLASH_DIV);

  localparam logic [IDX_W-1:0]      c_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]     c_SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FLASH_W-1:0]    c_FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
  localparam logic [4*NUM_DIGITS-1:0] c_ALL_BLANK = {NUM_DIGITS{4'hF}};

  function automatic logic [6:0] f_decode(input logic [3:0] i_code);
    case (i_code)
      4'h0:    f_decode = 7'b0111111;
      4'h1:    f_decode = 7'b0000011;
      4'h2:    f_decode = 7'b1101101;
      4'h3:    f_decode = 7'b1100111;
      4'h4:    f_decode = 7'b1010011;
      4'h5:    f_decode = 7'b1110110;
      4'h6:    f_decode = 7'b1111110;
      4'h7:    f_decode = 7'b0100011;
      4'h8:    f_decode = 7'b1111111;
      4'h9:    f_decode = 7'b1110111;
      4'hF:    f_decode = 7'b0000000;
      default: f_decode = 7'b1000000;
    endcase
  endfunction

  logic [SCAN_W-1:0]       r_scan_cnt;
  logic [IDX_W-1:0]        r_dig_idx;
  logic [FLASH_W-1:0]      r_flash_cnt;
  logic                    r_flash_phase;
  logic [4*NUM_DIGITS-1:0] r_pend_dig;
  logic [NUM_DIGITS-1:0]   r_pend_mask;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_disp_dig;
  logic [NUM_DIGITS-1:0]   r_disp_mask;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig_sel;
  logic                    r_frame_done;

  logic       w_slot_end;
  logic       w_boundary;
  logic [3:0] w_cur_code;
  logic       w_cur_mask;
  logic       w_blank;

  assign w_slot_end = (r_scan_cnt == c_SCAN_LAST);
  assign w_boundary = w_slot_end && (r_dig_idx == c_IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
    end else if (w_slot_end) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= (r_dig_idx == c_IDX_LAST) ? '0 : r_dig_idx + IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Free-running flash timebase, deliberately unrelated to the scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flash_cnt   <= '0;
      r_flash_phase <= 1'b0;
    end else if (r_flash_cnt == c_FLASH_LAST) begin
      r_flash_cnt   <= '0;
      r_flash_phase <= ~r_flash_phase;
    end else begin
      r_flash_cnt <= r_flash_cnt + FLASH_W'(1);
    end
  end

  // Display only changes at the frame boundary, so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_dig   <= c_ALL_BLANK;
      r_pend_mask  <= '0;
      r_pend_valid <= 1'b0;
      r_disp_dig   <= c_ALL_BLANK;
      r_disp_mask  <= '0;
    end else begin
      if (w_boundary && r_pend_valid) begin
        r_disp_dig   <= r_pend_dig;
        r_disp_mask  <= r_pend_mask;
        r_pend_valid <= 1'b0;
      end
      if (load) begin
        r_pend_dig   <= digits_in;
        r_pend_mask  <= flash_mask;
        r_pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    w_cur_code = 4'hF;
    w_cur_mask = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_dig_idx == IDX_W'(k)) begin
        w_cur_code = r_disp_dig[4*k +: 4];
        w_cur_mask = r_disp_mask[k];
      end
    end
  end

  assign w_blank = r_flash_phase & w_cur_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= '0;
      r_dig_sel    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_blank ? 7'b0000000 : f_decode(w_cur_code);
      r_dig_sel    <= NUM_DIGITS'(1) << r_dig_idx;
      r_frame_done <= w_boundary;
    end
  end

  assign seg_out    = r_seg;
  assign dig_sel    = r_dig_sel;
  assign frame_done = r_frame_done;

`ifdef SEVEN_SEG_DP_EN
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic                  r_dp;
  logic                  w_cur_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_dp <= '0;
      r_disp_dp <= '0;
    end else begin
      if (w_boundary && r_pend_valid) begin
        r_disp_dp <= r_pend_dp;
      end
      if (load) begin
        r_pend_dp <= dp_in;
      end
    end
  end

  always_comb begin
    w_cur_dp = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_dig_idx == IDX_W'(k)) begin
        w_cur_dp = r_disp_dp[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp <= 1'b0;
    end else begin
      r_dp <= w_cur_dp & ~w_blank;
    end
  end

  assign dp_out = r_dp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// Self-checking bench for seven_seg_scan: vector table, directed corner
// sequences and random traffic checked against a cycle-count reference model.
module tb_seven_seg_scan;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int FD    = 32;
  localparam int FRAME = ND * SD;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        load       = 1'b0;
  logic [15:0] digits_in  = 16'hFFFF;
  logic [3:0]  flash_mask = 4'b0000;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;
`ifdef SEVEN_SEG_DP_EN
  logic [3:0]  dp_in = 4'b0000;
  logic [0:0]  dp_out;
`endif

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .FLASH_DIV (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .load      (load),
    .flash_mask(flash_mask),
`ifdef SEVEN_SEG_DP_EN
    .dp_in     (dp_in),
    .dp_out    (dp_out),
`endif
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] ref_seg [16];

  // Reference model: everything derives from m_c, the number of clock edges since reset release.
  int          m_c;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pmask, m_dmask;
  logic        m_pv;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_fd;

  typedef struct packed {
    logic [15:0] digits;
    logic [27:0] exp;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_c     = 0;
    m_pend  = 16'hFFFF;
    m_disp  = 16'hFFFF;
    m_pmask = 4'b0000;
    m_dmask = 4'b0000;
    m_pv    = 1'b0;
    exp_seg = 7'd0;
    exp_sel = 4'd0;
    exp_fd  = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [15:0] d, input logic [3:0] m);
    int idx;
    int ph;
    logic [3:0] code;
    idx     = (m_c / SD) % ND;
    ph      = (m_c / FD) % 2;
    code    = m_disp[idx*4 +: 4];
    exp_sel = 4'(1 << idx);
    exp_seg = (ph == 1 && m_dmask[idx]) ? 7'd0 : ref_seg[code];
    exp_fd  = (m_c % FRAME == FRAME - 1);
    if ((m_c % FRAME == FRAME - 1) && m_pv) begin
      m_disp  = m_pend;
      m_dmask = m_pmask;
      m_pv    = 1'b0;
    end
    if (ld) begin
      m_pend  = d;
      m_pmask = m;
      m_pv    = 1'b1;
    end
    m_c++;
  endtask

  task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] m);
    load       = ld;
    digits_in  = d;
    flash_mask = m;
    @(posedge clk);
    model_step(ld, d, m);
    #1 load = 1'b0;
    @(negedge clk);
    chk("seg_out", 32'(seg_out), 32'(exp_seg));
    chk("dig_sel", 32'(dig_sel), 32'(exp_sel));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, digits_in, flash_mask);
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < FRAME && (m_c % FRAME) != phase; i++) tick(1'b0, digits_in, flash_mask);
  endtask

  // Assert reset between clock edges and check outputs clear without waiting for a clock.
  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_seg", 32'(seg_out), 32'd0);
    chk("rst_async_sel", 32'(dig_sel), 32'd0);
    chk("rst_async_fd", 32'(frame_done), 32'd0);
    model_reset();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rst_hold_seg", 32'(seg_out), 32'd0);
      chk("rst_hold_sel", 32'(dig_sel), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int slot, cnt5, cnt9, lit0, blank0, blank3, nonzero;

    ref_seg[0]  = 7'b0111111; ref_seg[1]  = 7'b0000011; ref_seg[2]  = 7'b1101101;
    ref_seg[3]  = 7'b1100111; ref_seg[4]  = 7'b1010011; ref_seg[5]  = 7'b1110110;
    ref_seg[6]  = 7'b1111110; ref_seg[7]  = 7'b0100011; ref_seg[8]  = 7'b1111111;
    ref_seg[9]  = 7'b1110111;
    for (int i = 10; i < 15; i++) ref_seg[i] = 7'b1000000;
    ref_seg[15] = 7'b0000000;

    vecs[0] = '{16'h1234, {7'b0000011, 7'b1101101, 7'b1100111, 7'b1010011}};
    vecs[1] = '{16'hABFF, {7'b1000000, 7'b1000000, 7'b0000000, 7'b0000000}};
    vecs[2] = '{16'h9090, {7'b1110111, 7'b0111111, 7'b1110111, 7'b0111111}};
    vecs[3] = '{16'h5678, {7'b1110110, 7'b1111110, 7'b0100011, 7'b1111111}};
    vecs[4] = '{16'h0F3E, {7'b0111111, 7'b0000000, 7'b1100111, 7'b1000000}};

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_seg", 32'(seg_out), 32'd0);
    chk("reset_sel", 32'(dig_sel), 32'd0);
    chk("reset_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Scan sequence with blank display after reset.
    idle(2 * FRAME + 3);

    // Decode table: each load must appear intact in the following frame.
    for (int v = 0; v < 5; v++) begin
      tick(1'b1, vecs[v].digits, 4'b0000);
      tick(1'b0, digits_in, 4'b0000);
      align(0);
      for (int i = 0; i < FRAME; i++) begin
        tick(1'b0, digits_in, 4'b0000);
        slot = ((m_c - 1) / SD) % ND;
        chk("vec_seg", 32'(seg_out), 32'(vecs[v].exp[7*slot +: 7]));
      end
    end

    // No tearing: two loads in one frame, only the last is ever shown.
    align(4);
    tick(1'b1, 16'h5678, 4'b0000);
    tick(1'b0, 16'h5678, 4'b0000);
    tick(1'b1, 16'h9090, 4'b0000);
    cnt5 = 0;
    cnt9 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0, digits_in, 4'b0000);
      if (dig_sel == 4'b1000 && seg_out == 7'b1110110) cnt5++;
      if (dig_sel == 4'b1000 && seg_out == 7'b1110111) cnt9++;
    end
    chk("no_tear_5678", 32'(cnt5), 32'd0);
    chk("shows_9090", 32'(cnt9 > 0), 32'd1);

    // Flash on digits 1,0 only.
    tick(1'b1, 16'h8888, 4'b0011);
    lit0 = 0;
    blank0 = 0;
    blank3 = 0;
    for (int i = 0; i < 4 * FD; i++) begin
      tick(1'b0, digits_in, flash_mask);
      if (i > FRAME + 2) begin
        if (dig_sel == 4'b0001 && seg_out == 7'b0000000) blank0++;
        if (dig_sel == 4'b0001 && seg_out == 7'b1111111) lit0++;
        if (dig_sel == 4'b1000 && seg_out != 7'b1111111) blank3++;
      end
    end
    chk("flash_blank_d0", 32'(blank0 > 0), 32'd1);
    chk("flash_lit_d0", 32'(lit0 > 0), 32'd1);
    chk("flash_steady_d3", 32'(blank3), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
    end

    // Reset mid-slot with pending data: pending must never surface.
    tick(1'b1, 16'h1234, 4'b0000);
    idle(2 * FRAME);
    align(5);
    tick(1'b1, 16'h5678, 4'b0000);
    async_reset(3);
    nonzero = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(1'b0, digits_in, 4'b0000);
      if (seg_out != 7'b0000000) nonzero++;
    end
    chk("post_reset_blank", 32'(nonzero), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
